// File: rtl/instr_mem_loader_if.sv
// Boot byte-stream handshake between a bootloader source and instr_mem_loader.
interface instr_mem_loader_if;
    logic       load_start;
    logic       boot_valid;
    logic [7:0] boot_byte;
    logic       boot_last;
    logic       boot_ready;

    modport master (
        output load_start, boot_valid, boot_byte, boot_last,
        input  boot_ready
    );

    modport slave (
        input  load_start, boot_valid, boot_byte, boot_last,
        output boot_ready
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory with a byte-serial bootloader write path and a registered
// PC-addressed read port; reads are masked to NOP_WORD while a load is active.
module instr_mem_loader #(
    parameter int unsigned DEPTH    = 1024,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_mem_loader_if.slave      boot,
    output logic                   loading,
    output logic                   load_done,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] word_count,
    input  logic [31:0]            pc_in,
    output logic [31:0]            instr,
    output logic                   misaligned
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {RUN, LOAD, DONE} state_t;

    state_t      state;
    logic [1:0]  idx;
    logic [31:0] asm_word;
    logic [31:0] mem [DEPTH];

    logic        accept;
    logic        commit;
    logic        full;
    logic        mem_we;
    logic [31:0] word_next;

    // Lanes below idx come from the assembly register, lane idx takes the
    // incoming byte, lanes above are zero so a partial final word is clean.
    always_comb begin
        word_next = '0;
        for (int unsigned l = 0; l < 4; l++) begin
            if (l < 32'(idx))
                word_next[8*l +: 8] = asm_word[8*l +: 8];
            else if (l == 32'(idx))
                word_next[8*l +: 8] = boot.boot_byte;
        end
    end

    assign accept = boot.boot_valid && boot.boot_ready;
    assign commit = accept && ((idx == 2'd3) || boot.boot_last);
    assign full   = (word_count == (AW+1)'(DEPTH));
    assign mem_we = commit && !full;

    // word_count doubles as the write pointer: both advance only on a stored word.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[word_count[AW-1:0]] <= word_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr      <= NOP_WORD;
            misaligned <= 1'b0;
        end else begin
            misaligned <= (pc_in[1:0] != 2'b00);
            if ((state != RUN) || (pc_in[31:AW+2] != '0))
                instr <= NOP_WORD;
            else
                instr <= mem[pc_in[AW+1:2]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= RUN;
            idx             <= '0;
            asm_word        <= '0;
            boot.boot_ready <= 1'b0;
            loading         <= 1'b0;
            load_done       <= 1'b0;
            overflow        <= 1'b0;
            word_count      <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (boot.load_start) begin
                        state           <= LOAD;
                        idx             <= '0;
                        asm_word        <= '0;
                        word_count      <= '0;
                        overflow        <= 1'b0;
                        boot.boot_ready <= 1'b1;
                        loading         <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        asm_word <= word_next;
                        idx      <= idx + 2'd1;
                        if (commit) begin
                            if (full)
                                overflow <= 1'b1;
                            else
                                word_count <= word_count + 1'b1;
                        end
                        if (boot.boot_last) begin
                            state           <= DONE;
                            boot.boot_ready <= 1'b0;
                            load_done       <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= RUN;
                    load_done <= 1'b0;
                    loading   <= 1'b0;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, instruction words stored; power of two, minimum 4.
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000013, word returned when no valid instruction is available.
REQ-003 SHALL derive AW = log2(DEPTH) internally. It SHALL NOT be a port-level parameter.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port load_start  in  1  single-cycle pulse that opens a bootloader load session.
REQ-007 SHALL have port boot_valid  in  1  boot_byte is valid.
REQ-008 SHALL have port boot_byte  in  8  instruction byte, little-endian order within each word.
REQ-009 SHALL have port boot_last  in  1  qualifies the final byte of the session.
REQ-010 SHALL have port boot_ready  out  1  block accepts a byte this cycle.
REQ-011 SHALL have port loading  out  1  a session is active; the core uses it as a stall.
REQ-012 SHALL have port load_done  out  1  one-cycle pulse at the end of a session.
REQ-013 SHALL have port overflow  out  1  sticky; bytes beyond DEPTH words were dropped.
REQ-014 SHALL have port word_count  out  AW+1  number of words committed in the last or current session.
REQ-015 SHALL have port pc_in  in  32  byte address from the PC.
REQ-016 SHALL have port instr  out  32  registered instruction.
REQ-017 SHALL have port misaligned  out  1  registered; pc_in[1:0] was non-zero.

Function
REQ-018 SHALL implement FSM states RUN, LOAD, DONE; RUN is the reset state.
REQ-019 RUN: boot_ready=0 and loading=0; load_start=1 SHALL move to LOAD and clear byte index, write pointer, word_count and overflow.
REQ-020 LOAD: boot_ready=1 and loading=1; a byte SHALL be accepted only when boot_valid && boot_ready; load_start SHALL be ignored.
REQ-021 Accepted byte SHALL go to lane idx (bits 8*idx+7:8*idx) of the assembly register; idx increments mod 4.
REQ-022 When idx==3 on an accepted byte, the assembled word SHALL be written to mem[ptr] in that same cycle; ptr and word_count SHALL then increment.
REQ-023 boot_last on an accepted byte with idx!=3: the partial word SHALL be written with unfilled upper lanes zeroed, and counted as one word.
REQ-024 boot_last on an accepted byte SHALL move to DONE.
REQ-025 If ptr==DEPTH at a word commit, the word SHALL be dropped; overflow=1 and word_count SHALL saturate at DEPTH.
REQ-026 DONE SHALL last exactly one cycle with load_done=1, loading=1 and boot_ready=0, then return to RUN.
REQ-027 Read SHALL have 1-cycle latency: instr <= mem[pc_in[AW+1:2]] each clk.
REQ-028 If pc_in >= 4*DEPTH, or the FSM is in LOAD or DONE, instr SHALL be loaded with NOP_WORD instead.
REQ-029 misaligned <= (pc_in[1:0]!=0) each cycle; the word-aligned read SHALL still occur.
REQ-030 Read and write to the same word in one cycle SHALL return NOP_WORD, because reads are masked in LOAD.
REQ-031 Memory SHALL be preloadable by initial contents and SHALL be inferable as block RAM (one write port, one read port).

Reset
REQ-032 rst=1 SHALL force, asynchronously: RUN, idx=0, ptr=0, assembly register=0, boot_ready=0, loading=0, load_done=0, overflow=0, word_count=0, instr=NOP_WORD, misaligned=0.
REQ-033 rst SHALL NOT clear memory contents.
REQ-034 rst asserted mid-LOAD SHALL abort the session; already-committed words remain; no load_done pulse SHALL be issued.

Verification
REQ-035 Preload then run: reset, pc_in=0x0 -> instr=preloaded mem[0] one cycle later; pc_in=0x4 -> mem[1]; pc_in=4*DEPTH -> 32'h00000013.
REQ-036 Full-word load: load_start, then bytes 93 00 10 00 with boot_last on the 4th -> mem[0]=32'h00100093, word_count=1, load_done high exactly one cycle, loading then low.
REQ-037 Partial-word load: 6 bytes 01..06, last on 06 -> mem[0]=32'h04030201, mem[1]=32'h00000605, word_count=2.
REQ-038 Overflow: DEPTH=4, send 20 bytes -> words 0..3 written, overflow=1, word_count=4, mem unchanged beyond word 3.
REQ-039 Backpressure/stall: boot_valid toggling randomly -> only handshaken bytes stored; instr=NOP_WORD throughout LOAD and DONE; misaligned=1 for pc_in=0x6.
REQ-040 Reset mid-load: assert rst after 5 bytes -> outputs take reset values immediately, mem[0] retains its committed word, and a new load_start starts a fresh session at ptr=0.
